// File: rtl/sram_port_arbiter_pkg.sv
// Shared definitions for the SRAM port arbiter: owner encoding and SRAM word geometry.
package sram_port_arbiter_pkg;

    localparam int DW  = 32;
    localparam int BEW = 4;

    typedef enum logic {
        REQ_INST = 1'b0,
        REQ_DATA = 1'b1
    } req_owner_e;

endpackage

// File: rtl/sram_port_arbiter_rsp_hold_buf.sv
// One-entry skid register for a read response the consumer could not take.
// While full it replays the held word; a fresh response passes straight through otherwise.
module sram_port_arbiter_rsp_hold_buf
    import sram_port_arbiter_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid_i,
    input  logic [DW-1:0] in_rdata_i,
    input  logic          rready_i,
    output logic          rvalid_o,
    output logic [DW-1:0] rdata_o,
    output logic          full_o
);

    logic          full_q;
    logic          full_d;
    logic [DW-1:0] data_q;
    logic [DW-1:0] data_d;

    // Capture an unaccepted fresh response, release the held one on the first ready cycle
    always_comb begin
        full_d = full_q;
        data_d = data_q;
        if (full_q) begin
            if (rready_i) begin
                full_d = 1'b0;
            end else begin
                full_d = 1'b1;
            end
        end else if (in_valid_i && !rready_i) begin
            full_d = 1'b1;
            data_d = in_rdata_i;
        end else begin
            full_d = 1'b0;
        end
    end

    // Hold register state
    always_ff @(posedge clk) begin
        if (rst) begin
            full_q <= 1'b0;
            data_q <= {DW{1'b0}};
        end else begin
            full_q <= full_d;
            data_q <= data_d;
        end
    end

    // Held word has priority; outputs are quiet during reset and when nothing is valid
    always_comb begin
        rvalid_o = 1'b0;
        rdata_o  = {DW{1'b0}};
        if (rst) begin
            rvalid_o = 1'b0;
        end else if (full_q) begin
            rvalid_o = 1'b1;
            rdata_o  = data_q;
        end else if (in_valid_i) begin
            rvalid_o = 1'b1;
            rdata_o  = in_rdata_i;
        end else begin
            rvalid_o = 1'b0;
        end
    end

    assign full_o = full_q;

endmodule

// File: rtl/sram_port_arbiter.sv
// Shares one single-port synchronous SRAM between fetch (inst) and memory-stage (data)
// requesters, with a streak limit so fetch is never starved behind data.
module sram_port_arbiter
    import sram_port_arbiter_pkg::*;
#(
    parameter int STREAK_MAX = 4,
    parameter int AW         = 32
)
(
    input  logic           clk,
    input  logic           rst,
    input  logic           inst_req,
    input  logic [AW-1:0]  inst_addr,
    output logic           inst_gnt,
    output logic           inst_rvalid,
    input  logic           inst_rready,
    output logic [DW-1:0]  inst_rdata,
    input  logic           data_req,
    input  logic [BEW-1:0] data_wen,
    input  logic [AW-1:0]  data_addr,
    input  logic [DW-1:0]  data_wdata,
    output logic           data_gnt,
    output logic           data_rvalid,
    input  logic           data_rready,
    output logic [DW-1:0]  data_rdata,
    output logic           sram_en,
    output logic [BEW-1:0] sram_wen,
    output logic [AW-1:0]  sram_addr,
    output logic [DW-1:0]  sram_wdata,
    input  logic [DW-1:0]  sram_rdata
);

    localparam int             SW         = $clog2(STREAK_MAX + 1);
    localparam logic [SW-1:0]  STREAK_TOP = SW'(STREAK_MAX);

    logic [SW-1:0] streak_q;
    logic [SW-1:0] streak_d;
    logic          rd_pend_q;
    logic          rd_pend_d;
    req_owner_e    rd_owner_q;
    req_owner_e    rd_owner_d;

    logic inst_fresh_s;
    logic data_fresh_s;
    logic inst_full_s;
    logic data_full_s;
    logic inst_elig_s;
    logic data_elig_s;
    logic inst_gnt_s;
    logic data_gnt_s;
    logic data_rd_s;

    assign inst_fresh_s = rd_pend_q && (rd_owner_q == REQ_INST);
    assign data_fresh_s = rd_pend_q && (rd_owner_q == REQ_DATA);

    // A fresh response about to be refused will occupy the hold next cycle, so it blocks too
    assign inst_elig_s = !rst && inst_req && !inst_full_s && !(inst_fresh_s && !inst_rready);
    assign data_elig_s = !rst && data_req && !data_full_s && !(data_fresh_s && !data_rready);

    // Data wins unless inst has waited through a full streak
    always_comb begin
        data_gnt_s = 1'b0;
        inst_gnt_s = 1'b0;
        if (data_elig_s && !(inst_elig_s && (streak_q == STREAK_TOP))) begin
            data_gnt_s = 1'b1;
        end else if (inst_elig_s) begin
            inst_gnt_s = 1'b1;
        end else begin
            data_gnt_s = 1'b0;
        end
    end

    assign data_rd_s = data_gnt_s && (data_wen == {BEW{1'b0}});

    // SRAM command mux from the winner
    always_comb begin
        sram_en    = inst_gnt_s | data_gnt_s;
        sram_wen   = {BEW{1'b0}};
        sram_addr  = {AW{1'b0}};
        sram_wdata = {DW{1'b0}};
        if (data_gnt_s) begin
            sram_wen   = data_wen;
            sram_addr  = data_addr;
            sram_wdata = data_wdata;
        end else if (inst_gnt_s) begin
            sram_addr  = inst_addr;
        end else begin
            sram_addr  = {AW{1'b0}};
        end
    end

    // Streak and in-flight read bookkeeping
    always_comb begin
        streak_d   = streak_q;
        rd_pend_d  = inst_gnt_s | data_rd_s;
        rd_owner_d = rd_owner_q;
        if (inst_gnt_s || !inst_req) begin
            streak_d = {SW{1'b0}};
        end else if (data_gnt_s && (streak_q != STREAK_TOP)) begin
            streak_d = streak_q + {{(SW-1){1'b0}}, 1'b1};
        end else begin
            streak_d = streak_q;
        end
        if (inst_gnt_s) begin
            rd_owner_d = REQ_INST;
        end else if (data_rd_s) begin
            rd_owner_d = REQ_DATA;
        end else begin
            rd_owner_d = rd_owner_q;
        end
    end

    // Arbiter state registers
    always_ff @(posedge clk) begin
        if (rst) begin
            streak_q   <= {SW{1'b0}};
            rd_pend_q  <= 1'b0;
            rd_owner_q <= REQ_INST;
        end else begin
            streak_q   <= streak_d;
            rd_pend_q  <= rd_pend_d;
            rd_owner_q <= rd_owner_d;
        end
    end

    sram_port_arbiter_rsp_hold_buf u_inst_hold (
        .clk        (clk),
        .rst        (rst),
        .in_valid_i (inst_fresh_s),
        .in_rdata_i (sram_rdata),
        .rready_i   (inst_rready),
        .rvalid_o   (inst_rvalid),
        .rdata_o    (inst_rdata),
        .full_o     (inst_full_s)
    );

    sram_port_arbiter_rsp_hold_buf u_data_hold (
        .clk        (clk),
        .rst        (rst),
        .in_valid_i (data_fresh_s),
        .in_rdata_i (sram_rdata),
        .rready_i   (data_rready),
        .rvalid_o   (data_rvalid),
        .rdata_o    (data_rdata),
        .full_o     (data_full_s)
    );

    assign inst_gnt = inst_gnt_s;
    assign data_gnt = data_gnt_s;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed bench for sram_port_arbiter: SRAM model, queue-based response model checked
// every cycle, and hand-computed literal expectations for each scenario.
module tb_sram_port_arbiter;

    localparam int SMAX = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        inst_req, inst_gnt, inst_rvalid, inst_rready;
    logic [31:0] inst_addr, inst_rdata;
    logic        data_req, data_gnt, data_rvalid, data_rready;
    logic [3:0]  data_wen, sram_wen;
    logic [31:0] data_addr, data_wdata, data_rdata;
    logic        sram_en;
    logic [31:0] sram_addr, sram_wdata, sram_rdata;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sram_port_arbiter #(.STREAK_MAX(SMAX), .AW(32)) dut (
        .clk(clk), .rst(rst),
        .inst_req(inst_req), .inst_addr(inst_addr), .inst_gnt(inst_gnt),
        .inst_rvalid(inst_rvalid), .inst_rready(inst_rready), .inst_rdata(inst_rdata),
        .data_req(data_req), .data_wen(data_wen), .data_addr(data_addr),
        .data_wdata(data_wdata), .data_gnt(data_gnt), .data_rvalid(data_rvalid),
        .data_rready(data_rready), .data_rdata(data_rdata),
        .sram_en(sram_en), .sram_wen(sram_wen), .sram_addr(sram_addr),
        .sram_wdata(sram_wdata), .sram_rdata(sram_rdata)
    );

    // SRAM: 256 words indexed by addr[9:2], initial word i = 0xA5000000 | i
    logic [31:0] mem [0:255];
    logic        mem_init;

    function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                          input logic [3:0] be);
        logic [31:0] r;
        r = old_w;
        for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = new_w[8*b +: 8];
        return r;
    endfunction

    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 256; i++) mem[i] <= 32'hA500_0000 | 32'(i);
        end else if (sram_en) begin
            if (sram_wen == 4'h0) sram_rdata <= mem[sram_addr[9:2]];
            else mem[sram_addr[9:2]] <= merge(mem[sram_addr[9:2]], sram_wdata, sram_wen);
        end
    end

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", nm, $time, got, exp);
        end
    endtask

    // Response model: per-requester queue of words owed; 'first' marks a word presented for the first time
    typedef struct { logic [31:0] w; bit first; } ent_t;
    ent_t q_i[$];
    ent_t q_d[$];
    int   streak_m = 0;

    always @(negedge clk) begin
        bit ei, ed, gi, gd;
        logic [31:0] ea, ewd;
        logic [3:0]  ew;
        ent_t e;
        gi = 1'b0; gd = 1'b0;
        if (!rst && !mem_init) begin
            ei = inst_req && (q_i.size() == 0 || (q_i[0].first && inst_rready));
            ed = data_req && (q_d.size() == 0 || (q_d[0].first && data_rready));
            gd = ed && !(ei && streak_m == SMAX);
            gi = ei && !gd;
        end
        ea  = gd ? data_addr  : (gi ? inst_addr : 32'h0);
        ew  = gd ? data_wen   : 4'h0;
        ewd = gd ? data_wdata : 32'h0;
        chk("inst_gnt", {31'h0, inst_gnt}, {31'h0, gi});
        chk("data_gnt", {31'h0, data_gnt}, {31'h0, gd});
        chk("sram_en", {31'h0, sram_en}, {31'h0, gi | gd});
        chk("sram_addr", sram_addr, ea);
        chk("sram_wen", {28'h0, sram_wen}, {28'h0, ew});
        chk("sram_wdata", sram_wdata, ewd);
        chk("inst_rvalid", {31'h0, inst_rvalid}, {31'h0, !rst && q_i.size() > 0});
        chk("data_rvalid", {31'h0, data_rvalid}, {31'h0, !rst && q_d.size() > 0});
        if (!rst && q_i.size() > 0) chk("inst_rdata", inst_rdata, q_i[0].w);
        if (!rst && q_d.size() > 0) chk("data_rdata", data_rdata, q_d[0].w);

        if (rst || mem_init) begin
            q_i.delete(); q_d.delete(); streak_m = 0;
        end else begin
            if (q_i.size() > 0) begin
                e = q_i.pop_front();
                if (!inst_rready) begin e.first = 1'b0; q_i.push_front(e); end
            end
            if (q_d.size() > 0) begin
                e = q_d.pop_front();
                if (!data_rready) begin e.first = 1'b0; q_d.push_front(e); end
            end
            if (gi) begin e.w = mem[inst_addr[9:2]]; e.first = 1'b1; q_i.push_back(e); end
            if (gd && data_wen == 4'h0) begin
                e.w = mem[data_addr[9:2]]; e.first = 1'b1; q_d.push_back(e);
            end
            if (gi || !inst_req) streak_m = 0;
            else if (gd && streak_m < SMAX) streak_m++;
        end
    end

    logic        s_igt, s_dgt, s_en, s_irv, s_drv;
    logic [3:0]  s_wen;
    logic [31:0] s_ird, s_drd, s_addr;

    task automatic step(input bit ir, input logic [31:0] ia, input bit irr,
                        input bit dr, input logic [3:0] dw, input logic [31:0] da,
                        input logic [31:0] dd, input bit drr);
        inst_req = ir; inst_addr = ia; inst_rready = irr;
        data_req = dr; data_wen = dw; data_addr = da; data_wdata = dd; data_rready = drr;
        @(negedge clk); #1;
        s_igt = inst_gnt; s_dgt = data_gnt; s_en = sram_en; s_wen = sram_wen;
        s_irv = inst_rvalid; s_ird = inst_rdata; s_drv = data_rvalid; s_drd = data_rdata;
        s_addr = sram_addr;
        @(posedge clk); #1;
    endtask

    task automatic idle(input bit irr, input bit drr);
        step(1'b0, 32'h0, irr, 1'b0, 4'h0, 32'h0, 32'h0, drr);
    endtask

    logic [9:0] hist;

    initial begin
        rst = 1'b1; mem_init = 1'b1;
        inst_req = 1'b0; inst_addr = 32'h0; inst_rready = 1'b1;
        data_req = 1'b0; data_wen = 4'h0; data_addr = 32'h0; data_wdata = 32'h0; data_rready = 1'b1;
        repeat (3) @(posedge clk);
        #1; mem_init = 1'b0; rst = 1'b0;

        idle(1'b1, 1'b1);
        chk("reset_sram_en", {31'h0, s_en}, 32'h0);
        chk("reset_rvalid", {30'h0, s_irv, s_drv}, 32'h0);

        // Inst-only reads
        step(1'b1, 32'hBFC0_0000, 1'b1, 1'b0, 4'h0, 32'h0, 32'h0, 1'b1);
        chk("t1_gnt", {31'h0, s_igt}, 32'h1);
        chk("t1_addr", s_addr, 32'hBFC0_0000);
        step(1'b1, 32'hBFC0_0004, 1'b1, 1'b0, 4'h0, 32'h0, 32'h0, 1'b1);
        chk("t1_rd0", s_ird, 32'hA500_0000);
        step(1'b1, 32'hBFC0_0008, 1'b1, 1'b0, 4'h0, 32'h0, 32'h0, 1'b1);
        chk("t1_rd1", s_ird, 32'hA500_0001);
        idle(1'b1, 1'b1);
        chk("t1_rd2", s_ird, 32'hA500_0002);

        // Data write then read-back
        step(1'b0, 32'h0, 1'b1, 1'b1, 4'hF, 32'h100, 32'hDEAD_BEEF, 1'b1);
        chk("t2_wr_wen", {28'h0, s_wen}, 32'hF);
        step(1'b0, 32'h0, 1'b1, 1'b1, 4'h0, 32'h100, 32'h0, 1'b1);
        chk("t2_wr_norvalid", {31'h0, s_drv}, 32'h0);
        chk("t2_rd_gnt", {31'h0, s_dgt}, 32'h1);
        idle(1'b1, 1'b1);
        chk("t2_rd_data", s_drd, 32'hDEAD_BEEF);

        // Both requesting: D,D,D,D,I repeating
        hist = 10'h0;
        for (int k = 0; k < 10; k++) begin
            step(1'b1, 32'hBFC0_0000 + 32'(4*k), 1'b1, 1'b1, 4'h0, 32'h200 + 32'(4*k), 32'h0, 1'b1);
            hist = {hist[8:0], s_igt};
        end
        chk("t3_pattern", {22'h0, hist}, 32'b0000100001);
        idle(1'b1, 1'b1);

        // Inst stalled on rready: hold replays while data proceeds
        step(1'b1, 32'hBFC0_0010, 1'b1, 1'b0, 4'h0, 32'h0, 32'h0, 1'b1);
        for (int k = 0; k < 3; k++) begin
            step(1'b1, 32'hBFC0_0014, 1'b0, 1'b1, 4'h0, 32'h300, 32'h0, 1'b1);
            chk("t4_igt", {31'h0, s_igt}, 32'h0);
            chk("t4_dgt", {31'h0, s_dgt}, 32'h1);
            chk("t4_hold", s_ird, 32'hA500_0004);
        end
        step(1'b1, 32'hBFC0_0014, 1'b1, 1'b1, 4'h0, 32'h300, 32'h0, 1'b1);
        chk("t4_drain_rv", {31'h0, s_irv}, 32'h1);
        chk("t4_drain_igt", {31'h0, s_igt}, 32'h0);
        step(1'b1, 32'hBFC0_0014, 1'b1, 1'b1, 4'h0, 32'h300, 32'h0, 1'b1);
        chk("t4_eligible", {31'h0, s_igt}, 32'h1);
        idle(1'b1, 1'b1);

        // Reset right after a data read grant
        step(1'b0, 32'h0, 1'b1, 1'b1, 4'h0, 32'h100, 32'h0, 1'b1);
        chk("t5_gnt", {31'h0, s_dgt}, 32'h1);
        rst = 1'b1;
        idle(1'b1, 1'b1);
        chk("t5_rst_rv", {31'h0, s_drv}, 32'h0);
        rst = 1'b0;
        idle(1'b1, 1'b1);
        chk("t5_post_outs", {s_igt, s_dgt, s_en, s_irv, s_drv, s_wen}, 32'h0);
        chk("t5_post_data", s_drd | s_ird | s_addr, 32'h0);
        idle(1'b1, 1'b1);
        chk("t5_late_rv", {31'h0, s_drv}, 32'h0);

        // Both hold buffers full: SRAM idles
        step(1'b1, 32'hBFC0_0020, 1'b0, 1'b1, 4'h0, 32'h104, 32'h0, 1'b0);
        chk("t6_dgt", {31'h0, s_dgt}, 32'h1);
        step(1'b1, 32'hBFC0_0020, 1'b0, 1'b1, 4'h0, 32'h104, 32'h0, 1'b0);
        chk("t6_igt", {31'h0, s_igt}, 32'h1);
        for (int k = 0; k < 2; k++) begin
            step(1'b1, 32'hBFC0_0020, 1'b0, 1'b1, 4'h0, 32'h104, 32'h0, 1'b0);
            chk("t6_idle_en", {31'h0, s_en}, 32'h0);
            chk("t6_both_rv", {30'h0, s_irv, s_drv}, 32'h3);
        end
        idle(1'b1, 1'b0);
        chk("t6_inst_drain", s_ird, 32'hA500_0008);
        idle(1'b1, 1'b1);
        chk("t6_data_drain", s_drd, 32'hA500_0041);
        idle(1'b1, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
